// File: rtl/fb_defs_pkg.sv
// fb_defs: framebuffer geometry, pixel format and writer state encoding shared with the scan-out side
package fb_defs;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 8;
    localparam int OFFSET_X = 160;
    localparam int OFFSET_Y = 120;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/fb_rect_writer_if.sv
// fb_rect_writer_if: command handshake, RAM write port and status of the rectangle writer
interface fb_rect_writer_if #(
    parameter int ADDR_W  = fb_defs::ADDR_W,
    parameter int COLOR_W = fb_defs::COLOR_W
);
    logic               init_done;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [8:0]         cmd_x0;
    logic [7:0]         cmd_y0;
    logic [8:0]         cmd_w;
    logic [7:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  ram_address;
    logic [COLOR_W-1:0] ram_data_in;
    logic               ram_wren;
    logic               busy;
    logic               done;
    modport master (
        output init_done, cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, ram_address, ram_data_in, ram_wren, busy, done
    );
    modport slave (
        input  init_done, cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
        output cmd_ready, ram_address, ram_data_in, ram_wren, busy, done
    );
endinterface

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clips a rectangle to the frame, giving exclusive end column/row and an empty flag
module fb_rect_clip #(
    parameter int FB_W = fb_defs::FB_W,
    parameter int FB_H = fb_defs::FB_H
) (
    input  logic [8:0] x0,
    input  logic [7:0] y0,
    input  logic [8:0] w,
    input  logic [7:0] h,
    output logic [9:0] x_end,
    output logic [8:0] y_end,
    output logic       empty
);
    logic [9:0] xs, ys;
    always_comb begin
        xs    = {1'b0, x0} + {1'b0, w};
        ys    = {2'b0, y0} + {2'b0, h};
        x_end = (xs > 10'(FB_W)) ? 10'(FB_W) : xs;
        y_end = (ys > 10'(FB_H)) ? 9'(FB_H) : ys[8:0];
        empty = (x0 >= 9'(FB_W)) || ({1'b0, y0} >= 9'(FB_H)) || (w == '0) || (h == '0);
    end
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: clips rectangle-fill commands and streams one framebuffer write per clock
module fb_rect_writer #(
    parameter int FB_W    = fb_defs::FB_W,
    parameter int FB_H    = fb_defs::FB_H,
    parameter int ADDR_W  = fb_defs::ADDR_W,
    parameter int COLOR_W = fb_defs::COLOR_W
) (
    input logic clock,
    input logic reset,
    fb_rect_writer_if.slave bus
);
    import fb_defs::state_t;
    import fb_defs::IDLE;
    import fb_defs::SETUP;
    import fb_defs::FILL;
    import fb_defs::DONE;

    state_t             state, nxt;
    logic [8:0]         x0_r, w_r, x, nx;
    logic [7:0]         y0_r, h_r, y, ny;
    logic [COLOR_W-1:0] color_r;
    logic [ADDR_W-1:0]  row_base, nbase;
    logic [9:0]         x_end, cx_end;
    logic [8:0]         y_end, cy_end;
    logic               c_empty, accept, last_col, last_row;

    fb_rect_clip #(.FB_W(FB_W), .FB_H(FB_H)) u_clip (
        .x0(x0_r), .y0(y0_r), .w(w_r), .h(h_r),
        .x_end(cx_end), .y_end(cy_end), .empty(c_empty)
    );

    assign accept        = state == IDLE && bus.cmd_valid && bus.init_done;
    assign bus.cmd_ready = state == IDLE && bus.init_done && !reset;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign last_col      = ({1'b0, x} + 10'd1) == x_end;
    assign last_row      = ({1'b0, y} + 9'd1) == y_end;

    // nx/ny/nbase name the pixel on the write port next cycle, so the port itself can be registered
    always_comb begin
        nxt   = state;
        nx    = x;
        ny    = y;
        nbase = row_base;
        case (state)
            IDLE:  nxt = accept ? SETUP : IDLE;
            SETUP: begin
                nxt   = c_empty ? DONE : FILL;
                nx    = x0_r;
                ny    = y0_r;
                nbase = ADDR_W'({y0_r, 8'b0}) + ADDR_W'({y0_r, 6'b0});
            end
            FILL: begin
                nxt   = (last_col && last_row) ? DONE : FILL;
                nx    = last_col ? x0_r : x + 9'd1;
                ny    = last_col ? y + 8'd1 : y;
                nbase = last_col ? row_base + ADDR_W'(FB_W) : row_base;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            bus.ram_wren    <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_data_in <= '0;
        end else begin
            state           <= nxt;
            x               <= nx;
            y               <= ny;
            row_base        <= nbase;
            bus.ram_wren    <= nxt == FILL;
            bus.ram_address <= (nxt == FILL) ? nbase + ADDR_W'(nx) : '0;
            bus.ram_data_in <= (nxt == FILL) ? color_r : '0;
            if (accept) begin
                x0_r    <= bus.cmd_x0;
                y0_r    <= bus.cmd_y0;
                w_r     <= bus.cmd_w;
                h_r     <= bus.cmd_h;
                color_r <= bus.cmd_color;
            end
            if (state == SETUP) begin
                x_end <= cx_end;
                y_end <= cy_end;
            end
        end
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: directed and random rectangle fills checked against a pixel-list reference model
module tb_fb_rect_writer;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fb_rect_writer_if bus ();
    fb_rect_writer dut (.clock(clock), .reset(reset), .bus(bus));

    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.ram_wren) begin
            checks++;
            assert (bus.ram_address <= 19'd76799) else begin
                errors++;
                $error("FAIL addr_range: observed %0d expected <= 76799", bus.ram_address);
            end
        end
    end

    // Called at a negedge with the engine idle; returns at the negedge where cmd_ready is back.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input logic [7:0] col);
        int q[$];
        int xe, ye, n;
        bus.cmd_x0    = 9'(x0);
        bus.cmd_y0    = 8'(y0);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 8'(h);
        bus.cmd_color = col;
        bus.cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("ready_wait", 64'(n), 64'd0);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = 9'($urandom);
        bus.cmd_y0    = 8'($urandom);
        bus.cmd_w     = 9'($urandom);
        bus.cmd_h     = 8'($urandom);
        bus.cmd_color = 8'($urandom);
        xe = (x0 + w > 320) ? 320 : x0 + w;
        ye = (y0 + h > 240) ? 240 : y0 + h;
        if (x0 < 320 && y0 < 240 && w > 0 && h > 0)
            for (int yy = y0; yy < ye; yy++)
                for (int xx = x0; xx < xe; xx++)
                    q.push_back(yy * 320 + xx);
        @(negedge clock);
        check("setup", {bus.busy, bus.cmd_ready, bus.ram_wren, bus.done}, 4'b1000);
        foreach (q[i]) begin
            @(negedge clock);
            check("pixel", {bus.ram_wren, bus.ram_address, bus.ram_data_in}, {1'b1, 19'(q[i]), col});
        end
        @(negedge clock);
        check("done", {bus.busy, bus.done, bus.ram_wren, bus.cmd_ready}, 4'b1100);
        @(negedge clock);
        check("idle", {bus.busy, bus.done, bus.ram_wren, bus.cmd_ready}, {3'b000, bus.init_done});
    endtask

    initial begin
        int cnt, n;
        reset         = 1'b1;
        bus.init_done = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_vals", {bus.cmd_ready, bus.ram_wren, bus.ram_address, bus.ram_data_in, bus.busy, bus.done}, '0);
        reset = 1'b0;

        // Gating: command pending while RAM not initialised
        bus.cmd_x0    = 9'd0;
        bus.cmd_y0    = 8'd0;
        bus.cmd_w     = 9'd1;
        bus.cmd_h     = 8'd1;
        bus.cmd_color = 8'hAB;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("gated", {bus.cmd_ready, bus.ram_wren, bus.busy}, 3'b000);
        end
        bus.init_done = 1'b1;
        run_cmd(0, 0, 1, 1, 8'hAB);

        run_cmd(10, 5, 3, 2, 8'h3C);
        run_cmd(318, 239, 5, 5, 8'hFF);
        run_cmd(100, 50, 0, 4, 8'h11);
        run_cmd(320, 0, 8, 8, 8'h22);
        run_cmd(0, 240, 4, 4, 8'h33);
        run_cmd(319, 0, 1, 1, 8'h44);

        // Full-screen clear abandoned by reset after 1000 writes
        bus.cmd_x0    = 9'd0;
        bus.cmd_y0    = 8'd0;
        bus.cmd_w     = 9'd320;
        bus.cmd_h     = 8'd240;
        bus.cmd_color = 8'h55;
        bus.cmd_valid = 1'b1;
        #1;
        check("clr_ready", bus.cmd_ready, 1'b1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        cnt = 0;
        n   = 0;
        while (cnt < 1000 && n < 1100) begin
            @(negedge clock);
            n++;
            if (bus.ram_wren) begin
                check("clr_pixel", {bus.ram_address, bus.ram_data_in}, {19'(cnt), 8'h55});
                cnt++;
            end
        end
        check("clr_count", 64'(cnt), 64'd1000);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_mid", {bus.cmd_ready, bus.ram_wren, bus.busy, bus.done}, 4'b0000);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_idle", {bus.cmd_ready, bus.ram_wren, bus.busy}, 3'b100);
        run_cmd(7, 3, 1, 1, 8'h12);

        repeat (40) begin
            run_cmd($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 12),
                    $urandom_range(0, 6), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_rect_writer.md
# fb_rect_writer

Framebuffer write engine: the writer side of the 320x240, 8-bit-per-pixel frame RAM that the VGA scan-out path reads. It accepts rectangle-fill commands (single pixel = 1x1 rectangle, clear screen = full-frame rectangle) over a valid/ready handshake. Each command is clipped to the frame, then issued as one RAM write per clock on the same address/data/wren port that the display logic drives into the RAM access block. It runs in the 25 MHz pixel clock domain.

## Interface

Parameters:
- FB_W, 320, frame width in pixels
- FB_H, 240, frame height in pixels
- ADDR_W, 19, RAM address width
- COLOR_W, 8, pixel width

Ports:
- clock  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- init_done  in  1  RAM initialised; no command is accepted while low
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  9  left column
- cmd_y0  in  8  top row
- cmd_w  in  9  width in pixels
- cmd_h  in  8  height in pixels
- cmd_color  in  COLOR_W  fill value
- ram_address  out  ADDR_W  write address, row-major: y*FB_W + x
- ram_data_in  out  COLOR_W  write data
- ram_wren  out  1  write strobe; one pixel per high cycle
- busy  out  1  command in progress (SETUP, FILL or DONE)
- done  out  1  one-cycle pulse when a command completes

## Operation

- States: IDLE, SETUP, FILL, DONE.
- **IDLE**
  - cmd_ready = init_done.
  - A command is accepted on `cmd_valid && cmd_ready`. All cmd_* fields are latched on that edge, and the state moves to SETUP.
  - cmd_* are ignored at all other times.
- **SETUP** (one cycle): clipping.
  - x_end = min(x0+w, FB_W); y_end = min(y0+h, FB_H). Sums are computed at 10 bits, so there is no overflow.
  - Empty case: if x0 ≥ FB_W, y0 ≥ FB_H, w = 0 or h = 0, the command is empty and the state goes directly to DONE with no writes.
  - Otherwise: x = x0, y = y0, row_base = y0*FB_W computed as (y0<<8)+(y0<<6). Then go to FILL.
- **FILL**: each cycle, issue a write with ram_wren=1, ram_address = row_base + x, ram_data_in = color.
  - Then x++. When x+1 == x_end: x = x0, y++, row_base += FB_W.
  - When the last pixel is issued (x+1 == x_end and y+1 == y_end), the next state is DONE.
- **DONE** (one cycle): done=1, cmd_ready=0, ram_wren=0. Next state is IDLE.
- Outputs ram_address, ram_data_in and ram_wren are registered. Outside FILL: ram_wren=0, ram_data_in=0, ram_address=0.
- Addresses never exceed FB_W*FB_H−1 (76799).
- **init_done falling mid-command:** the command continues to completion. This is legal only after reset, so it is not a supported case.
- **Reset asserted in any state:** on that edge all outputs take their reset values and the state becomes IDLE. The in-flight command is abandoned; pixels already written stay written.

## Timing

- Reset values: cmd_ready=0, ram_address=0, ram_data_in=0, ram_wren=0, busy=0, done=0.
  - cmd_ready rises the first cycle after reset deasserts, provided init_done=1.
- Accept on edge N:
  - busy=1 and cmd_ready=0 from N+1.
  - SETUP during cycle N+1.
  - First write visible during cycle N+2.
  - Writes continue back-to-back, with no bubbles at row wrap, for P = clipped_w*clipped_h cycles.
  - done=1 during cycle N+2+P; busy stays high through this cycle.
  - cmd_ready=1 again at N+3+P.
- Empty command: done during cycle N+2, cmd_ready back at N+3.
- Throughput: one pixel/clock. Per-command overhead is 3 cycles (SETUP, DONE, IDLE accept).
- cmd_valid may stay high across commands. A new command is accepted only in IDLE.

## Structure

- Shared package/include `fb_defs`:
  - FB_W, FB_H, ADDR_W, COLOR_W
  - OFFSET_X=160, OFFSET_Y=120, also used by the scan-out side
  - the state encoding (2-bit localparams IDLE/SETUP/FILL/DONE)
- One natural sub-module, `fb_rect_clip`: combinational clipping of x0/y0/w/h into x_end, y_end and an empty flag, registered by the parent in SETUP.
- Address generation (row_base accumulator plus x counter) and the FSM stay in the top module.

## Test plan

- **Single pixel:** init_done=1, cmd (0,0,1,1,0xAB).
  - Exactly one cycle with wren=1, address 0, data 0xAB, two cycles after accept.
  - done one cycle later.
- **Rectangle:** (10,5,3,2,0x3C).
  - Writes, in consecutive cycles: 1610, 1611, 1612, 1930, 1931, 1932.
  - done during cycle N+8.
- **Clipping:** (318,239,5,5,0xFF).
  - Writes only 76798 and 76799.
  - No address > 76799 ever appears.
- **Empty command:** (100,50,0,4) and separately (320,0,8,8).
  - Zero writes; done during cycle N+2; cmd_ready high at N+3.
- **Gating:** init_done=0 with cmd_valid held high.
  - cmd_ready stays 0 and no writes occur.
  - After init_done rises, the command is accepted on the next edge.
- **Reset mid-fill:** full-screen clear (0,0,320,240), reset pulsed after 1000 writes.
  - wren=0, busy=0 and done=0 on the edge after reset.
  - Exactly 1000 writes (addresses 0..999) were issued.
  - A following 1x1 command executes normally.
